// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel-priority / bus-request stage.
package dma_pkg;

  // Default number of DMA channels (DREQ/DACK width).
  localparam int DMA_NUM_CH = 4;

  // Bit positions inside the 8-bit command register.
  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

  // Arbiter / bus-request state, one-hot encoded.
  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    HOLD_REQ = 4'b0010,
    ACTIVE   = 4'b0100,
    RELEASE  = 4'b1000
  } arb_state_e;

  // Channel-index width; never below one bit so a single-channel build still elaborates.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Next channel after ch, wrapping at n.
  function automatic int next_ch(input int ch, input int n);
    return (ch + 1 >= n) ? 0 : ch + 1;
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Handshake bundle between the priority arbiter, the channel request lines,
// the CPU hold logic and the timing-and-control state machine.
interface dma_priority_arbiter_if
  import dma_pkg::*;
#(
  parameter int NUM_CH = DMA_NUM_CH
);
  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] DREQ;          // raw channel requests
  logic              HLDA;          // hold acknowledge from CPU
  logic              serviceDone;   // end-of-service pulse from timing-and-control
  logic              HRQ;           // hold request to CPU
  logic [NUM_CH-1:0] DACK;          // channel acknowledge
  logic [CH_W-1:0]   activeCh;      // granted channel
  logic              serviceStart;  // grant-valid pulse to timing-and-control

  // Arbiter side.
  modport master (
    input  DREQ, HLDA, serviceDone,
    output HRQ, DACK, activeCh, serviceStart
  );

  // Environment side (channels, CPU, timing-and-control).
  modport slave (
    output DREQ, HLDA, serviceDone,
    input  HRQ, DACK, activeCh, serviceStart
  );

endinterface

// File: rtl/dma_prio_encoder.sv
// Combinational rotating-priority picker: returns the first set request bit
// scanning ptr, ptr+1, ... with wrap-around.
module dma_prio_encoder
  import dma_pkg::*;
#(
  parameter int NUM_CH = DMA_NUM_CH,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   winner,
  output logic              any_req
);

  int unsigned     idx;
  logic [CH_W-1:0] idx_w;

  // Scan from the pointer upward with wrap and keep the first hit.
  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path through the loop can infer a latch.
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_w = CH_W'(idx);
      if (!any_req && req[idx_w]) begin
        winner  = idx_w;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237-style channel priority and bus-request stage: samples DREQ, applies
// mask/software requests, picks a channel by fixed or rotating priority, runs
// the HRQ/HLDA handshake, drives DACK and hands the grant to timing-and-control.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = DMA_NUM_CH,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  dma_priority_arbiter_if.master  bus,
  input  logic [NUM_CH-1:0]       maskReg,
  input  logic [NUM_CH-1:0]       requestReg,
  input  logic                    controllerDisable,
  input  logic                    rotatingPriority,
  input  logic                    dreqActiveLow,
  input  logic                    dackActiveHigh
);

  arb_state_e        state_q, state_d;
  logic [NUM_CH-1:0] dreq_q, dreq_d;
  logic [CH_W-1:0]   active_ch_q, active_ch_d;
  logic [CH_W-1:0]   prio_ptr_q, prio_ptr_d;
  logic              hrq_q, hrq_d;
  logic              service_start_q, service_start_d;

  logic [NUM_CH-1:0] eff_req;
  logic [CH_W-1:0]   eff_ptr;
  logic [CH_W-1:0]   winner;
  logic              any_req;
  logic [NUM_CH-1:0] grant;

  // Requests seen by arbitration: sampled hardware requests not masked, plus software requests.
  assign eff_req = (dreq_q & ~maskReg) | requestReg;

  // Fixed mode always scans from channel 0; the rotating pointer is preserved regardless.
  assign eff_ptr = rotatingPriority ? prio_ptr_q : '0;

  dma_prio_encoder #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_prio_encoder (
    .req     (eff_req),
    .ptr     (eff_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Next-state logic for the sampling stage, the handshake FSM and the priority pointer.
  always_comb begin
    dreq_d      = bus.DREQ ^ {NUM_CH{dreqActiveLow}};
    state_d     = state_q;
    active_ch_d = active_ch_q;
    prio_ptr_d  = prio_ptr_q;

    unique case (state_q)
      IDLE: begin
        if (any_req && !controllerDisable) begin
          state_d     = HOLD_REQ;
          active_ch_d = winner;
        end
      end
      HOLD_REQ: begin
        // A withdrawn request only cancels while the CPU has not yet granted the bus.
        if (!eff_req[active_ch_q] && !bus.HLDA) state_d = IDLE;
        else if (bus.HLDA)                      state_d = ACTIVE;
      end
      ACTIVE: begin
        // End of service wins over a coincident HLDA drop; only a completed service rotates.
        if (bus.serviceDone) begin
          state_d = RELEASE;
          if (rotatingPriority) prio_ptr_d = CH_W'(next_ch(int'(active_ch_q), NUM_CH));
        end else if (!bus.HLDA) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    hrq_d           = (state_d == HOLD_REQ) || (state_d == ACTIVE);
    service_start_d = (state_q == HOLD_REQ) && (state_d == ACTIVE);
  end

  // State and registered outputs; synchronous reset overrides everything, including mid-service.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= IDLE;
      dreq_q          <= '0;
      active_ch_q     <= '0;
      prio_ptr_q      <= '0;
      hrq_q           <= 1'b0;
      service_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop captures values computed from pre-edge state.
      state_q         <= state_d;
      dreq_q          <= dreq_d;
      active_ch_q     <= active_ch_d;
      prio_ptr_q      <= prio_ptr_d;
      hrq_q           <= hrq_d;
      service_start_q <= service_start_d;
    end
  end

  // DACK follows the registered state; polarity applies combinationally.
  assign grant    = (state_q == ACTIVE) ? (NUM_CH'(1) << active_ch_q) : '0;
  assign bus.DACK = dackActiveHigh ? grant : ~grant;

  assign bus.HRQ          = hrq_q;
  assign bus.activeCh     = active_ch_q;
  assign bus.serviceStart = service_start_q;

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
Channel priority and bus-request stage of the 8237-style DMA controller. It sits directly upstream of the timing-and-control state machine. It samples DREQ, applies the mask and software-request registers, and picks one channel by fixed or rotating priority. It then runs the HRQ/HLDA handshake with the CPU, drives DACK, and hands the granted channel to timing-and-control through a one-cycle start pulse. It holds the grant until timing-and-control signals end of service.

Parameters:
NUM_CH, 4, number of DMA channels (DREQ/DACK width).
CH_W, $clog2(NUM_CH), width of the channel index.

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
DREQ  input  NUM_CH  raw channel requests; polarity set by dreqActiveLow
maskReg  input  NUM_CH  1 = channel masked
requestReg  input  NUM_CH  software requests; never masked, always active-high
controllerDisable  input  1  command bit 2; 1 = no new arbitration
rotatingPriority  input  1  command bit 4; 0 = fixed, 1 = rotating
dreqActiveLow  input  1  command bit 6
dackActiveHigh  input  1  command bit 7
HLDA  input  1  hold acknowledge from CPU
serviceDone  input  1  one-cycle pulse from timing-and-control at end of service (S4)
HRQ  output  1  hold request to CPU
DACK  output  NUM_CH  channel acknowledge, polarity per dackActiveHigh
activeCh  output  CH_W  granted channel index
serviceStart  output  1  one-cycle pulse to timing-and-control; grant valid

Behaviour:
- Request sampling
  - dreqQ <= DREQ ^ {NUM_CH{dreqActiveLow}} on every edge. This is one register stage.
  - effReq = (dreqQ & ~maskReg) | requestReg.
- States (one-hot, shared enum): IDLE, HOLD_REQ, ACTIVE, RELEASE.
- IDLE
  - Moves to HOLD_REQ when effReq != 0 and controllerDisable == 0.
  - On that transition, latches winner into activeCh.
  - HRQ is registered 1 the cycle after the transition. DREQ-to-HRQ latency is 2 cycles.
- HOLD_REQ
  - HRQ = 1.
  - If effReq[activeCh] == 0 and HLDA == 0, go to IDLE; HRQ returns to 0 next cycle. No rotation.
  - Else if HLDA == 1, go to ACTIVE.
  - The withdrawal check has precedence only when HLDA == 0. If HLDA == 1 in the same cycle as withdrawal, the grant proceeds.
- ACTIVE
  - HRQ = 1 and DACK[activeCh] is active.
  - serviceStart = 1 on the first ACTIVE cycle only.
  - On serviceDone, go to RELEASE and rotate priority.
  - If HLDA falls to 0 (without serviceDone), go to RELEASE with no rotation.
  - If serviceDone and an HLDA drop coincide, treat as serviceDone.
- RELEASE
  - HRQ = 0, all DACK inactive.
  - Always returns to IDLE next cycle. The minimum gap between grants is therefore 2 cycles (RELEASE + IDLE).
- Priority
  - prioPtr is the highest-priority channel index.
  - Fixed mode: the effective pointer is 0, so channel 0 is highest.
  - Rotating mode: on serviceDone, prioPtr <= (activeCh + 1) mod NUM_CH.
  - The winner is the first set effReq bit scanning prioPtr, prioPtr+1, … with wrap.
  - Switching the mode mid-operation takes effect at the next arbitration. prioPtr is kept.
- DACK encoding
  - Internal one-hot grant g = (state == ACTIVE) ? 1 << activeCh : 0.
  - DACK = dackActiveHigh ? g : ~g. This is combinational from the registered state, so a polarity change applies immediately.
- controllerDisable
  - Blocks only the IDLE-to-HOLD_REQ transition.
  - A grant already in progress completes normally.
- Reset (synchronous, overrides everything, including mid-service)
  - state = IDLE, HRQ = 0, serviceStart = 0.
  - activeCh = 0, prioPtr = 0, dreqQ = 0.
  - DACK = all inactive: 4'b1111 while dackActiveHigh = 0, 4'b0000 while dackActiveHigh = 1.

Decomposition:
- Package dma_pkg holds:
  - arbiter state enum and NUM_CH default;
  - command-register bit index constants (CMD_DISABLE = 2, CMD_ROTATE = 4, CMD_DREQ_LOW = 6, CMD_DACK_HIGH = 7).
- Sub-module dma_prio_encoder: combinational rotating-priority picker.
  - Inputs: req[NUM_CH], ptr[CH_W].
  - Outputs: winner[CH_W], anyReq.

Test Plan:
- Reset: RESET = 1 for 2 cycles with dackActiveHigh = 0 -> HRQ = 0, DACK = 4'b1111, serviceStart = 0, activeCh = 0. Repeat with dackActiveHigh = 1 -> DACK = 4'b0000.
- Fixed priority: dackActiveHigh = 1, DREQ = 4'b1010, HLDA = 1 -> HRQ = 1 two cycles after DREQ; then DACK = 4'b0010, activeCh = 1, serviceStart pulses once. After serviceDone -> RELEASE, HRQ = 0, DACK = 0.
- Rotating priority: rotatingPriority = 1, DREQ = 4'b1111 held, HLDA = 1, serviceDone pulsed in each service -> grant order 0, 1, 2, 3, 0.
- Mask and software request: maskReg = 4'b0001, DREQ = 4'b0001 for 10 cycles -> HRQ stays 0. Then requestReg = 4'b0001 -> HRQ = 1 and grant to channel 0.
- Withdrawal and HLDA loss:
  - DREQ = 4'b0100 to HOLD_REQ with HLDA = 0, then DREQ = 0 -> HRQ = 0 next cycle, no DACK.
  - Separately, HLDA dropped in ACTIVE -> RELEASE, prioPtr unchanged.
- Disable and polarity:
  - controllerDisable = 1 with DREQ = 4'b0001 -> no HRQ.
  - dreqActiveLow = 1 with DREQ = 4'b1110 -> channel 0 granted.
  - RESET asserted in ACTIVE -> next cycle IDLE, HRQ = 0.
